jtag_tap_ctrl: RTL

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_tap_pkg.sv | 29 ++
 rtl/jtag_tap_fsm.sv | 44 ++++
 rtl/jtag_tap_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encoding and instruction opcodes.
// Opcode widths depend on IR_W, so only the values live here.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RUN_IDLE   = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TEST_RESET = 4'hF
  } tap_state_e;

  // BYPASS is this bit replicated across the whole instruction register
  localparam logic OP_BYPASS_FILL = 1'b1;
  localparam int   OP_IDCODE      = 1;
  localparam int   OP_UDR_BASE    = 2;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 sixteen-state TAP controller, advancing on rising tck.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output logic [3:0] tap_state
);

  tap_state_e state_reg;
  tap_state_e state_next;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state_reg <= TEST_RESET;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = TEST_RESET;
    case (state_reg)
      TEST_RESET: state_next = tms ? TEST_RESET : RUN_IDLE;
      RUN_IDLE:   state_next = tms ? SELECT_DR  : RUN_IDLE;
      SELECT_DR:  state_next = tms ? SELECT_IR  : CAPTURE_DR;
      CAPTURE_DR: state_next = tms ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:   state_next = tms ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:   state_next = tms ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:   state_next = tms ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:   state_next = tms ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:  state_next = tms ? SELECT_DR  : RUN_IDLE;
      SELECT_IR:  state_next = tms ? TEST_RESET : CAPTURE_IR;
      CAPTURE_IR: state_next = tms ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:   state_next = tms ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:   state_next = tms ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:   state_next = tms ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:   state_next = tms ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:  state_next = tms ? SELECT_DR  : RUN_IDLE;
      default:    state_next = TEST_RESET;
    endcase
  end

  assign tap_state = state_reg;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP with IR, BYPASS, optional IDCODE and NUM_UDR user data registers.
// Define JTAG_TAP_IDCODE_EN to build IDCODE and make it the reset instruction.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          NUM_UDR    = 2,
  parameter int          UDR_W      = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                     tck,
  input  logic                     trst,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  input  logic [NUM_UDR*UDR_W-1:0] udr_capture_data,
  output logic [UDR_W-1:0]         udr_update_data,
  output logic [NUM_UDR-1:0]       udr_update_vld,
  output logic [3:0]               tap_state,
  output logic [IR_W-1:0]          ir_out
);

  localparam logic [IR_W-1:0] BYPASS_OP = {IR_W{OP_BYPASS_FILL}};
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] RESET_OP  = IR_W'(OP_IDCODE);
`else
  localparam logic [IR_W-1:0] RESET_OP  = BYPASS_OP;
`endif

  logic [3:0]   state_bits;
  tap_state_e   state;

  jtag_tap_fsm u_fsm (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms),
    .tap_state (state_bits)
  );

  assign state = tap_state_e'(state_bits);

  logic [IR_W-1:0]    ir_shift_reg;
  logic [IR_W-1:0]    ir_reg;
  logic               byp_reg;
  logic [UDR_W-1:0]   udr_shift_reg;
  logic [UDR_W-1:0]   udr_data_reg;
  logic [NUM_UDR-1:0] udr_vld_reg;
  logic               tdo_reg;
  logic               tdo_en_reg;

  logic [UDR_W-1:0]   cap_ch [NUM_UDR];
  logic [UDR_W-1:0]   cap_val;
  logic [NUM_UDR-1:0] vld_hot;
  logic               sel_udr;
  logic               sel_idcode;
  logic               dr_lsb;

  for (genvar gi = 0; gi < NUM_UDR; gi++) begin : g_cap
    assign cap_ch[gi] = udr_capture_data[gi*UDR_W +: UDR_W];
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_shift_reg;
  assign sel_idcode = (ir_reg == IR_W'(OP_IDCODE));
`else
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VAL;
  assign sel_idcode    = 1'b0;
`endif

  // Opcodes that match neither IDCODE nor an existing user channel fall back to BYPASS
  always_comb begin
    sel_udr = 1'b0;
    cap_val = '0;
    vld_hot = '0;
    for (int k = 0; k < NUM_UDR; k++) begin
      if (ir_reg == IR_W'(OP_UDR_BASE + k) && ir_reg != BYPASS_OP) begin
        sel_udr    = 1'b1;
        cap_val    = cap_ch[k];
        vld_hot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    dr_lsb = byp_reg;
    if (sel_udr) dr_lsb = udr_shift_reg[0];
`ifdef JTAG_TAP_IDCODE_EN
    else if (sel_idcode) dr_lsb = idcode_shift_reg[0];
`endif
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_shift_reg  <= '0;
      ir_reg        <= RESET_OP;
      byp_reg       <= 1'b0;
      udr_shift_reg <= '0;
      udr_data_reg  <= '0;
      udr_vld_reg   <= '0;
`ifdef JTAG_TAP_IDCODE_EN
      idcode_shift_reg <= '0;
`endif
    end else begin
      udr_vld_reg <= '0;
      case (state)
        TEST_RESET: ir_reg       <= RESET_OP;
        CAPTURE_IR: ir_shift_reg <= IR_W'(2'b01);
        SHIFT_IR:   ir_shift_reg <= {tdi, ir_shift_reg[IR_W-1:1]};
        UPDATE_IR:  ir_reg       <= ir_shift_reg;
        CAPTURE_DR: begin
          byp_reg       <= 1'b0;
          udr_shift_reg <= cap_val;
`ifdef JTAG_TAP_IDCODE_EN
          idcode_shift_reg <= IDCODE_VAL;
`endif
        end
        SHIFT_DR: begin
          byp_reg       <= tdi;
          udr_shift_reg <= {tdi, udr_shift_reg[UDR_W-1:1]};
`ifdef JTAG_TAP_IDCODE_EN
          idcode_shift_reg <= {tdi, idcode_shift_reg[31:1]};
`endif
        end
        UPDATE_DR: begin
          if (sel_udr) begin
            udr_data_reg <= udr_shift_reg;
            udr_vld_reg  <= vld_hot;
          end
        end
        default: ;
      endcase
    end
  end

  // Output launched on the falling edge so the receiver samples a settled bit
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo_reg    <= 1'b0;
      tdo_en_reg <= 1'b0;
    end else begin
      tdo_en_reg <= (state == SHIFT_IR) || (state == SHIFT_DR);
      if (state == SHIFT_IR)      tdo_reg <= ir_shift_reg[0];
      else if (state == SHIFT_DR) tdo_reg <= dr_lsb;
      else                        tdo_reg <= 1'b0;
    end
  end

  assign tdo             = tdo_reg;
  assign tdo_en          = tdo_en_reg;
  assign udr_update_data = udr_data_reg;
  assign udr_update_vld  = udr_vld_reg;
  assign tap_state       = state_bits;
  assign ir_out          = ir_reg;

endmodule
